// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out.
// Optional macro SER_PARITY_EN appends an even-parity bit after each word.
module seq_bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic IDLE  = 1'b0;
   localparam logic SHIFT = 1'b1;

`ifdef SER_PARITY_EN
   localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

   logic             state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             accept;
   logic             data_bit;
   logic [WIDTH-1:0] shifted;

   assign last      = (state == SHIFT) && (cnt == LAST);
   assign din_ready = !reset && ((state == IDLE) || last);
   assign accept    = din_valid && din_ready;

   assign data_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
   assign shifted  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                               : {1'b0, sreg[WIDTH-1:1]};

`ifdef SER_PARITY_EN
   logic par;

   always_ff @(posedge clk) begin
      if (reset)
         par <= 1'b0;
      else if (accept)
         par <= ^din;
   end

   // Final counter value selects the captured parity instead of the register
   assign bit_out = (state == SHIFT) && ((cnt == LAST) ? par : data_bit);
`else
   assign bit_out = (state == SHIFT) && data_bit;
`endif

   assign bit_valid = (state == SHIFT);
   assign busy      = (state == SHIFT);
   assign word_done = last;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else if (accept) begin
         state <= SHIFT;
         sreg  <= din;
         cnt   <= '0;
      end else if (state == SHIFT) begin
         if (last) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
         end else begin
            sreg <= shifted;
            cnt  <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances against a bit-queue model.
// Directed test-plan steps followed by a randomized stream with sporadic resets.
module tb_seq_bit_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] din;
   logic         din_valid;

   logic m_ready, m_bit, m_valid, m_done, m_busy;
   logic l_ready, l_bit, l_valid, l_done, l_busy;

   int checks = 0;
   int fails  = 0;
   bit last_acc;

   bit mq[$];
   bit lq[$];

   always #5 clk = ~clk;

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .din_ready(m_ready), .bit_out(m_bit), .bit_valid(m_valid),
      .word_done(m_done), .busy(m_busy)
   );

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .din_ready(l_ready), .bit_out(l_bit), .bit_valid(l_valid),
      .word_done(l_done), .busy(l_busy)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_side(input string s, input bit q[$],
                           input logic rdy, input logic b, input logic v,
                           input logic d, input logic bz);
      int n;
      n = q.size();
      chk({s, "_ready"}, rdy, !reset && n <= 1);
      chk({s, "_valid"}, v, n > 0);
      chk({s, "_busy"}, bz, n > 0);
      chk({s, "_done"}, d, n == 1);
      chk({s, "_bit"}, b, (n > 0) ? q[0] : 1'b0);
   endtask

   // Check at negedge, then advance the model across the posedge
   task automatic cycle();
      bit acc;
      @(negedge clk);
      chk_side("msb", mq, m_ready, m_bit, m_valid, m_done, m_busy);
      chk_side("lsb", lq, l_ready, l_bit, l_valid, l_done, l_busy);
      acc = !reset && din_valid && (mq.size() <= 1);
      @(posedge clk);
      if (reset) begin
         mq.delete();
         lq.delete();
      end else begin
         if (mq.size() > 0) void'(mq.pop_front());
         if (lq.size() > 0) void'(lq.pop_front());
         if (acc) begin
            for (int i = W - 1; i >= 0; i--) mq.push_back(din[i]);
            for (int i = 0; i < W; i++) lq.push_back(din[i]);
`ifdef SER_PARITY_EN
            mq.push_back(^din);
            lq.push_back(^din);
`endif
         end
      end
      last_acc = acc;
      #1;
   endtask

   task automatic send_wait(input logic [W-1:0] w);
      int k;
      din       = w;
      din_valid = 1'b1;
      k = 0;
      do begin
         cycle();
         k++;
      end while (!last_acc && k < 30);
      checks++;
      if (!last_acc) begin
         fails++;
         $error("FAIL accept_timeout observed=0 expected=1 t=%0t", $time);
      end
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      reset     = 1'b1;
      din       = '0;
      din_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cycle();
      reset = 1'b0;
      idle(2);

      send_wait(8'hA5);
      idle(11);

      din = 8'hA5;
      din_valid = 1'b1;
      cycle();
      send_wait(8'h3C);
      idle(12);

      send_wait(8'h01);
      idle(11);

      send_wait(8'hFF);
      din_valid = 1'b0;
      repeat (3) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      idle(3);
      send_wait(8'h80);
      idle(11);

      send_wait(8'h96);
      din_valid = 1'b0;
      cycle();
      send_wait(8'h55);
      idle(12);

      send_wait(8'h07);
      idle(12);

      for (int i = 0; i < 400; i++) begin
         din       = W'($urandom);
         din_valid = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 60) == 0);
         cycle();
      end
      reset = 1'b0;
      idle(12);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Parallel-to-serial front end for the serial sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on bit_out, with a bit_valid qualifier. The downstream sequence detector samples bit_out only in cycles where bit_valid=1. Consecutive words stream with no idle cycle between them.

Parameters:
WIDTH, 8, data word width in bits (>=2)
MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = shift out din[0] first

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din is valid this cycle
din_ready  output  1  block accepts din this cycle (combinational)
bit_out  output  1  current serial bit
bit_valid  output  1  bit_out is valid this cycle
word_done  output  1  this cycle carries the last bit of the word
busy  output  1  a word is being shifted (state SHIFT)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset applies on the clk edge where reset=1:
  - state=IDLE, shift register=0, bit counter=0.
  - bit_out=0, bit_valid=0, word_done=0, busy=0.
  - din_ready=0 while reset=1.
- States: IDLE, SHIFT.
- Accept: a transfer occurs on a clk edge where din_valid=1 and din_ready=1. No other edge loads data.
- din_ready = !reset and (state==IDLE, or state==SHIFT with counter==last bit).
- IDLE:
  - bit_valid=0, bit_out=0, busy=0.
  - On accept: load the shift register from din, set counter=0, go to SHIFT.
- SHIFT:
  - bit_valid=1, busy=1.
  - bit_out = MSB of the shift register (MSB_FIRST=1) or LSB (MSB_FIRST=0).
  - Each edge: shift one position toward the output end, zero-fill, and increment the counter.
- Last bit (counter==WIDTH-1):
  - word_done=1 for that cycle only.
  - If a new word is accepted on that edge: reload, counter=0, stay in SHIFT. The next bit is valid on the very next cycle (zero bubble).
  - Otherwise go to IDLE.
- Latency: the first bit appears on bit_out in the cycle after the accept edge. A word occupies exactly WIDTH consecutive bit_valid cycles.
- din_valid held high while din_ready=0: no effect, no loss. The word is taken at the next ready edge.
- din changing while din_ready=0: ignored.
- Reset mid-word: the partial word is discarded and no further bits are emitted. After reset deasserts, the block is in IDLE.
- Counter width: clog2(WIDTH+1) bits. The counter never wraps past the last-bit value.
- All outputs except din_ready are derived from registered state only, so there is no combinational path from din/din_valid to bit_out, bit_valid or word_done.

Optional Feature:
SER_PARITY_EN
- Defined:
  - After the WIDTH data bits, one extra even-parity bit is emitted (XOR of the accepted word) with bit_valid=1.
  - A word therefore takes WIDTH+1 cycles.
  - word_done and the back-to-back accept window (din_ready=1) move to the parity-bit cycle.
  - Parity is captured at accept time.
- Undefined: no parity bit. Timing is exactly as described in Behaviour.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, after reset accept din=8'hA5 -> over the next 8 cycles bit_out=1,0,1,0,0,1,0,1 with bit_valid=1; word_done=1 only on the 8th bit; then bit_valid=0 and busy=0.
2. Back-to-back: 8'hA5 then 8'h3C, with din_valid held high -> 16 contiguous bit_valid cycles, 1010_0101 then 0011_1100; din_ready=1 only in IDLE and in the two last-bit cycles.
3. MSB_FIRST=0, din=8'h01 -> bit_out=1,0,0,0,0,0,0,0.
4. Reset asserted for 1 cycle at the 4th bit of 8'hFF -> bit_valid=0 the next cycle; a new 8'h80 accepted later emits 1,0,0,0,0,0,0,0 cleanly.
5. din_valid=1 with din=8'h55 at the 2nd bit of a word, held high -> not taken until the last-bit edge; no word is lost or duplicated.
6. SER_PARITY_EN defined: 8'hA5 -> 9 bits, parity bit 0; 8'h07 -> parity bit 1; word_done on the 9th cycle.
